reg_context_sequencer: RTL and testbench
========================================

Name: reg_context_sequencer

Overview:
- Saves all eight general-purpose registers (R0–R7) to memory, or restores them from memory, in an automatic sequence. Used for interrupt entry/exit and debug snapshots.
- Sits between the CPU control FSM and the register file, and owns the register file's write/SR2 path while it runs.
- The CPU is stalled while the sequence runs.
- Talks to the memory subsystem through a req/ack handshake.

Parameters:
- DATA_W, 16, register and memory data width.
- ADDR_W, 16, memory address width.
- NUM_REGS, 8, number of registers sequenced. Fixed at 8; the index is 3 bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- save_req  in  1  start a save sequence; sampled only in IDLE.
- restore_req  in  1  start a restore sequence; sampled only in IDLE.
- base_addr  in  ADDR_W  base address of the context area; latched at sequence start.
- busy  out  1  sequence in progress; also the CPU stall signal.
- done  out  1  one-cycle pulse when a sequence completes.
- cpu_ld_reg  in  1  CPU register-load request.
- cpu_dr_code  in  3  CPU destination register code.
- cpu_sr2_code  in  3  CPU SR2 code.
- rf_ld_reg  out  1  LD_REG to the register file.
- rf_dr_code  out  3  destination code to the register file; the DRMUX result is overridden.
- rf_sr2_code  out  3  SR2 code to the register file.
- rf_sr2_data  in  DATA_W  SR2_out from the register file.
- rf_bus_sel  out  1  1 = sequencer drives the register-file input bus.
- rf_wdata  out  DATA_W  sequencer write data to the bus.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack = 1.
- mem_ack  in  1  memory acknowledge.

Behaviour:
- States: IDLE, SAVE, RESTORE_RD, RESTORE_WB, DONE. The index counter idx is 3 bits.
- Reset (synchronous, active-high):
  - Next state IDLE, idx = 0, capture register = 0.
  - After the reset edge, every output is 0: busy, done, rf_ld_reg, rf_bus_sel, mem_req, mem_we, mem_addr, mem_wdata, rf_wdata.
  - Reset asserted mid-sequence aborts it: mem_req drops after that edge and no done pulse is issued. Registers already written stay written.
- IDLE:
  - Pass-through: rf_ld_reg = cpu_ld_reg, rf_dr_code = cpu_dr_code, rf_sr2_code = cpu_sr2_code, rf_bus_sel = 0.
  - On save_req, go to SAVE; otherwise on restore_req, go to RESTORE_RD. If both are asserted, save wins.
  - On either start: latch base_addr and set idx = 0.
- Any non-IDLE state:
  - busy = 1.
  - cpu_ld_reg is blocked; rf_ld_reg is driven only by the sequencer.
  - save_req and restore_req are ignored.
- SAVE:
  - Drives rf_sr2_code = idx, mem_req = 1, mem_we = 1, mem_addr = base + idx (modulo 2^ADDR_W, wraps), mem_wdata = rf_sr2_data.
  - All of these are held stable until mem_ack is sampled high.
  - On ack: if idx == 7, go to DONE; else idx++.
- RESTORE_RD:
  - Drives mem_req = 1, mem_we = 0, mem_addr = base + idx.
  - On ack: capture mem_rdata and go to RESTORE_WB.
- RESTORE_WB (exactly one cycle):
  - Drives rf_bus_sel = 1, rf_wdata = captured value, rf_dr_code = idx, rf_ld_reg = 1.
  - Next state: DONE if idx == 7, else RESTORE_RD with idx++.
- DONE (one cycle): done = 1, busy = 1. Next state IDLE.
- Handshake:
  - mem_ack counts only in cycles where mem_req = 1; ack while mem_req = 0 is ignored.
  - A same-cycle (combinational) ack is legal.
  - There is no timeout; the sequencer waits indefinitely.
- Latency with zero-wait memory:
  - Save: 8 SAVE cycles + 1 DONE cycle. busy is high 9 cycles, starting the cycle after the request edge.
  - Restore: 16 + 1 = 17 busy cycles.
- A request held high continuously re-triggers a new sequence on the cycle after DONE returns to IDLE.

Decomposition:
- Shared package `lc3_ctx_pkg`:
  - `ctx_state_t` enum for the states.
  - `NUM_REGS = 8`.
  - `CTX_LAST_IDX = 3'd7`.
- Data capture uses the existing 16-bit load-enable register (`reg_16`).
- No other sub-module; the FSM and the address adder stay in this module.

Test Plan:
- Save with base 16'h3000, R0..R7 preloaded 16'h1110..16'h1117, ack every cycle:
  - 8 writes, address 3000..3007 with data 1110..1117 in order.
  - busy high for 9 cycles; done pulses once; no rf_ld_reg during the sequence.
- Restore from base 16'h4000 with memory holding A0A0+i, 2 wait states per read:
  - R0..R7 end as A0A0..A0A7.
  - Each register write is a single rf_ld_reg cycle; busy lasts 8*(3+1)+1 = 33 cycles.
- Base 16'hFFFC, save:
  - Addresses FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003.
- save_req and restore_req asserted in the same cycle:
  - A save runs (mem_we = 1 throughout).
  - A cpu_ld_reg pulse during busy does not reach rf_ld_reg.
- Reset asserted in the cycle after the 3rd write ack:
  - Next cycle: mem_req = 0, busy = 0, no done pulse.
  - Only locations base..base+2 were written.
- mem_ack pulsed while in IDLE, then a restore is started:
  - The stray ack causes no state change.
  - The first read still targets base + 0.

Source files
------------

// File: rtl/lc3_ctx_pkg.sv
// ---------------------------------------------------------------------------
// lc3_ctx_pkg
// Shared definitions for the register context save/restore sequencer.
//   ctx_state_t  : sequencer FSM states
//   NUM_REGS     : number of general-purpose registers sequenced (R0..R7)
//   CTX_LAST_IDX : index of the last register in a sequence
// ---------------------------------------------------------------------------
package lc3_ctx_pkg;

  localparam int NUM_REGS = 8;
  localparam logic [2:0] CTX_LAST_IDX = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    RESTORE_RD,
    RESTORE_WB,
    DONE
  } ctx_state_t;

endpackage

// File: rtl/reg_context_sequencer_reg_16.sv
// ---------------------------------------------------------------------------
// reg_16
// 16-bit register with load enable and synchronous active-high reset.
// Ports:
//   clk   in   system clock
//   reset in   synchronous active-high reset (clears q)
//   ld    in   load enable
//   d     in   16-bit data in
//   q     out  16-bit registered data
// ---------------------------------------------------------------------------
module reg_16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/reg_context_sequencer.sv
// ---------------------------------------------------------------------------
// reg_context_sequencer
// Saves R0..R7 to memory or restores them from memory in an automatic
// sequence. While running it stalls the CPU (busy) and owns the register
// file's load/DR/SR2 controls and its input bus.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   save_req, restore_req      start requests (sampled only in IDLE; save wins)
//   base_addr                  context area base, latched at start
//   busy, done                 sequence active / one-cycle completion pulse
//   cpu_ld_reg, cpu_dr_code,
//   cpu_sr2_code               CPU register-file controls (passed through in IDLE)
//   rf_ld_reg, rf_dr_code,
//   rf_sr2_code                controls to the register file
//   rf_sr2_data                SR2_out from the register file
//   rf_bus_sel, rf_wdata       sequencer drives the register-file input bus
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata,
//   mem_ack                    memory req/ack handshake (same-cycle ack legal)
// ---------------------------------------------------------------------------
module reg_context_sequencer
  import lc3_ctx_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  input  logic              cpu_ld_reg,
  input  logic [2:0]        cpu_dr_code,
  input  logic [2:0]        cpu_sr2_code,
  output logic              rf_ld_reg,
  output logic [2:0]        rf_dr_code,
  output logic [2:0]        rf_sr2_code,
  input  logic [DATA_W-1:0] rf_sr2_data,
  output logic              rf_bus_sel,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  ctx_state_t        state;
  logic [2:0]        idx;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] rd_data;
  logic              rd_capture;

  // Address wraps modulo 2^ADDR_W by plain truncation of the sum.
  logic [ADDR_W-1:0] seq_addr;
  assign seq_addr = base + ADDR_W'(idx);

  // Read data is captured only on a real ack of a pending read.
  assign rd_capture = (state == RESTORE_RD) && mem_ack;

  // NOTE: the capture register is reset too, so rf_wdata can never expose
  // stale data from a sequence aborted by reset.
  reg_16 u_capture (
    .clk   (clk),
    .reset (reset),
    .ld    (rd_capture),
    .d     (mem_rdata),
    .q     (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      base  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (save_req) begin
            state <= SAVE;
            idx   <= '0;
            base  <= base_addr;
          end else if (restore_req) begin
            state <= RESTORE_RD;
            idx   <= '0;
            base  <= base_addr;
          end
        end
        SAVE: begin
          if (mem_ack) begin
            if (idx == CTX_LAST_IDX) state <= DONE;
            else idx <= idx + 3'd1;
          end
        end
        RESTORE_RD: begin
          if (mem_ack) state <= RESTORE_WB;
        end
        RESTORE_WB: begin
          if (idx == CTX_LAST_IDX) begin
            state <= DONE;
          end else begin
            state <= RESTORE_RD;
            idx   <= idx + 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are a pure decode of the registered state (plus the IDLE
  // pass-through and the same-cycle SR2 read data during SAVE).
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    busy        = 1'b1;
    done        = 1'b0;
    rf_ld_reg   = 1'b0;
    rf_dr_code  = idx;
    rf_sr2_code = idx;
    rf_bus_sel  = 1'b0;
    rf_wdata    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state)
      IDLE: begin
        busy        = 1'b0;
        rf_ld_reg   = cpu_ld_reg;
        rf_dr_code  = cpu_dr_code;
        rf_sr2_code = cpu_sr2_code;
      end
      SAVE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = seq_addr;
        mem_wdata = rf_sr2_data;
      end
      RESTORE_RD: begin
        mem_req  = 1'b1;
        mem_addr = seq_addr;
      end
      RESTORE_WB: begin
        rf_bus_sel = 1'b1;
        rf_wdata   = rd_data;
        rf_ld_reg  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_reg_context_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_context_sequencer
// Directed bench for reg_context_sequencer with a behavioural register file
// and a memory that acks after a programmable number of wait cycles.
// ---------------------------------------------------------------------------
module tb_reg_context_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_req, restore_req;
  logic [15:0] base_addr;
  logic        busy, done;
  logic        cpu_ld_reg;
  logic [2:0]  cpu_dr_code, cpu_sr2_code;
  logic        rf_ld_reg;
  logic [2:0]  rf_dr_code, rf_sr2_code;
  logic [15:0] rf_sr2_data;
  logic        rf_bus_sel;
  logic [15:0] rf_wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  // Register file and memory models
  logic [15:0] regs [0:7];
  logic [15:0] mem  [0:65535];
  logic [15:0] cpu_bus_data = 16'hDEAD;
  int          ws = 0;
  int          wait_cnt = 0;
  logic        stray_ack = 1'b0;

  // Monitor counters and logs
  int          busy_cycles = 0;
  int          done_cnt = 0;
  int          seq_ld_cnt = 0;
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] rd_addr_q[$];

  always #5 clk = ~clk;

  reg_context_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .save_req     (save_req),
    .restore_req  (restore_req),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .cpu_ld_reg   (cpu_ld_reg),
    .cpu_dr_code  (cpu_dr_code),
    .cpu_sr2_code (cpu_sr2_code),
    .rf_ld_reg    (rf_ld_reg),
    .rf_dr_code   (rf_dr_code),
    .rf_sr2_code  (rf_sr2_code),
    .rf_sr2_data  (rf_sr2_data),
    .rf_bus_sel   (rf_bus_sel),
    .rf_wdata     (rf_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  assign rf_sr2_data = regs[rf_sr2_code];
  assign mem_rdata   = mem[mem_addr];
  assign mem_ack     = (mem_req && (wait_cnt >= ws)) || stray_ack;

  always @(posedge clk) begin
    if (rf_ld_reg) regs[rf_dr_code] <= rf_bus_sel ? rf_wdata : cpu_bus_data;
    if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(negedge clk) begin
    if (busy) busy_cycles <= busy_cycles + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy && rf_ld_reg) seq_ld_cnt <= seq_ld_cnt + 1;
    if (mem_req && mem_ack && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (mem_req && mem_ack && !mem_we) rd_addr_q.push_back(mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    busy_cycles = 0;
    done_cnt    = 0;
    seq_ld_cnt  = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  // Waits for the done pulse, then lets the negedge monitor record it.
  task automatic wait_done(input string name, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, max_cycles);
    end
    tick();
  endtask

  task automatic preload_regs(input logic [15:0] first);
    for (int i = 0; i < 8; i++) regs[i] = first + 16'(i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, rf_ld_reg, rf_bus_sel, mem_req, mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {busy, done, rf_ld_reg, rf_bus_sel, mem_req, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, rf_wdata} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, rf_wdata});
    end
    reset = 1'b0;
    cpu_ld_reg = 1'b1;
    cpu_dr_code = 3'd5;
    cpu_sr2_code = 3'd3;
    tick();
    checks++;
    if ({rf_ld_reg, rf_dr_code, rf_sr2_code, rf_bus_sel} !== {1'b1, 3'd5, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL idle_passthru got %b exp %b",
               {rf_ld_reg, rf_dr_code, rf_sr2_code, rf_bus_sel}, {1'b1, 3'd5, 3'd3, 1'b0});
    end
    cpu_ld_reg = 1'b0;
    tick();
  endtask

  task automatic test_save();
    preload_regs(16'h1110);
    ws = 0;
    clear_logs();
    base_addr = 16'h3000;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL save_busy_start got %b exp 1", busy);
    end
    wait_done("save", 100);
    checks++;
    if (wr_addr_q.size() != 8) begin
      errors++;
      $display("FAIL save_count got %0d exp 8", wr_addr_q.size());
    end
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      checks++;
      if ({wr_addr_q[i], wr_data_q[i]} !== {16'h3000 + 16'(i), 16'h1110 + 16'(i)}) begin
        errors++;
        $display("FAIL save_wr%0d got %h/%h exp %h/%h", i, wr_addr_q[i], wr_data_q[i],
                 16'h3000 + 16'(i), 16'h1110 + 16'(i));
      end
    end
    checks++;
    if (busy_cycles != 9) begin
      errors++;
      $display("FAIL save_busy_len got %0d exp 9", busy_cycles);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL save_done got %0d exp 1", done_cnt);
    end
    checks++;
    if (seq_ld_cnt != 0) begin
      errors++;
      $display("FAIL save_no_ld got %0d exp 0", seq_ld_cnt);
    end
  endtask

  task automatic test_restore();
    for (int i = 0; i < 8; i++) begin
      regs[i] = 16'h0;
      mem[16'h4000 + i] = 16'hA0A0 + 16'(i);
    end
    ws = 2;
    clear_logs();
    base_addr = 16'h4000;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    wait_done("restore", 200);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (regs[i] !== 16'hA0A0 + 16'(i)) begin
        errors++;
        $display("FAIL restore_r%0d got %h exp %h", i, regs[i], 16'hA0A0 + 16'(i));
      end
    end
    checks++;
    if (seq_ld_cnt != 8) begin
      errors++;
      $display("FAIL restore_ld_cycles got %0d exp 8", seq_ld_cnt);
    end
    checks++;
    if (busy_cycles != 33) begin
      errors++;
      $display("FAIL restore_busy_len got %0d exp 33", busy_cycles);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL restore_done got %0d exp 1", done_cnt);
    end
    ws = 0;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [0:7];
    exp_addr = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
                 16'h0000, 16'h0001, 16'h0002, 16'h0003};
    ws = 0;
    clear_logs();
    base_addr = 16'hFFFC;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    wait_done("wrap", 100);
    checks++;
    if (wr_addr_q.size() != 8) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 8", wr_addr_q.size());
    end
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d got %h exp %h", i, wr_addr_q[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_both_req();
    preload_regs(16'h1110);
    ws = 0;
    clear_logs();
    base_addr = 16'h7000;
    save_req = 1'b1;
    restore_req = 1'b1;
    tick();
    save_req = 1'b0;
    restore_req = 1'b0;
    tick();
    cpu_ld_reg = 1'b1;
    cpu_dr_code = 3'd2;
    checks++;
    if (rf_ld_reg !== 1'b0) begin
      errors++;
      $display("FAIL both_cpu_blocked got %b exp 0", rf_ld_reg);
    end
    tick();
    cpu_ld_reg = 1'b0;
    wait_done("both", 100);
    checks++;
    if (wr_addr_q.size() != 8 || rd_addr_q.size() != 0) begin
      errors++;
      $display("FAIL both_save_wins got wr=%0d rd=%0d exp wr=8 rd=0",
               wr_addr_q.size(), rd_addr_q.size());
    end
    checks++;
    if (regs[2] !== 16'h1112) begin
      errors++;
      $display("FAIL both_r2_intact got %h exp 1112", regs[2]);
    end
    checks++;
    if (seq_ld_cnt != 0) begin
      errors++;
      $display("FAIL both_no_ld got %0d exp 0", seq_ld_cnt);
    end
  endtask

  task automatic test_reset_abort();
    bit reached = 1'b0;
    for (int i = 0; i < 8; i++) mem[16'h5000 + i] = 16'hEEEE;
    preload_regs(16'h2220);
    ws = 2;
    clear_logs();
    base_addr = 16'h5000;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wr_addr_q.size() >= 3) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL abort_third_ack timeout got %0d writes exp 3", wr_addr_q.size());
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({mem_req, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle got %b exp 000", {mem_req, busy, done});
    end
    repeat (5) tick();
    checks++;
    if (done_cnt != 0 || wr_addr_q.size() != 3) begin
      errors++;
      $display("FAIL abort_no_done got done=%0d wr=%0d exp done=0 wr=3",
               done_cnt, wr_addr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] exp_val;
      exp_val = (i < 3) ? 16'h2220 + 16'(i) : 16'hEEEE;
      checks++;
      if (mem[16'h5000 + i] !== exp_val) begin
        errors++;
        $display("FAIL abort_mem%0d got %h exp %h", i, mem[16'h5000 + i], exp_val);
      end
    end
    ws = 0;
  endtask

  task automatic test_stray_ack();
    for (int i = 0; i < 8; i++) begin
      regs[i] = 16'h0;
      mem[16'h6000 + i] = 16'h5A00 + 16'(i);
    end
    ws = 0;
    clear_logs();
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick();
    checks++;
    if ({busy, mem_req, done} !== 3'b000) begin
      errors++;
      $display("FAIL stray_no_change got %b exp 000", {busy, mem_req, done});
    end
    base_addr = 16'h6000;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    wait_done("stray_restore", 100);
    checks++;
    if (rd_addr_q.size() == 0 || rd_addr_q[0] !== 16'h6000) begin
      errors++;
      $display("FAIL stray_first_rd got %h exp 6000",
               (rd_addr_q.size() == 0) ? 16'hxxxx : rd_addr_q[0]);
    end
    checks++;
    if (regs[0] !== 16'h5A00 || regs[7] !== 16'h5A07) begin
      errors++;
      $display("FAIL stray_regs got %h/%h exp 5a00/5a07", regs[0], regs[7]);
    end
  endtask

  task automatic test_back_to_back();
    ws = 0;
    clear_logs();
    base_addr = 16'h8000;
    save_req = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      tick();
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap got busy=%b exp 0", busy);
    end
    tick();
    checks++;
    if ({busy, mem_req, mem_we, mem_addr} !== {3'b111, 16'h8000}) begin
      errors++;
      $display("FAIL b2b_retrigger got %b/%h exp 111/8000",
               {busy, mem_req, mem_we}, mem_addr);
    end
    save_req = 1'b0;
    wait_done("b2b", 100);
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL b2b_done got %0d exp 2", done_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    save_req = 1'b0;
    restore_req = 1'b0;
    base_addr = 16'h0;
    cpu_ld_reg = 1'b0;
    cpu_dr_code = 3'd0;
    cpu_sr2_code = 3'd0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;

    test_reset();
    test_save();
    test_restore();
    test_wrap();
    test_both_req();
    test_reset_abort();
    test_stray_ack();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
